snake_step_controller: RTL and testbench
========================================

Name: snake_step_controller

Overview:
Game-sequencing controller for the snake head position recorder on the 8x8 grid. It latches player direction requests and paces movement with a tick divider, issuing one single-cycle l/r/u/d step pulse per tick. It loads the start position, detects wall hits and food pickup, keeps score, and runs the IDLE/LOAD/RUN/OVER game flow. It sits between the button logic and the position recorder.

Parameters:
TICK_DIV, 4, clock cycles per movement step (>=2)
COORD_W, 3, grid coordinate width (grid is 2**COORD_W per axis)
START_X, 3, x loaded at game start
START_Y, 3, y loaded at game start
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  level; begins a game from IDLE or OVER
btn_l, btn_r, btn_u, btn_d  in  1 each  direction requests, sampled every cycle
pos_x, pos_y  in  COORD_W each  current head position from recorder
edge_collision  in  1  wall-hit flag from recorder
food_x, food_y  in  COORD_W each  current food cell
l, r, u, d  out  1 each  one-cycle step pulses to recorder (at most one high)
load  out  1  one-cycle position load strobe to recorder
load_x, load_y  out  COORD_W each  load coordinates (START_X/START_Y, else 0)
playing  out  1  high in RUN
game_over  out  1  high in OVER
eat  out  1  one-cycle pulse on food pickup
score  out  SCORE_W  foods eaten this game

Behaviour:
- Reset values: state IDLE; l/r/u/d/load/eat/playing/game_over = 0; load_x = load_y = 0; score = 0; dir = RIGHT; tick = 0; chk = 0. Reset overrides all other inputs in every state.
- All outputs are registered.
- IDLE: all outputs idle. start=1 -> LOAD.
- LOAD (exactly 1 cycle): load=1, load_x=START_X, load_y=START_Y, score<=0, dir<=RIGHT, tick<=0. Next state is RUN.
- RUN: playing=1. start is ignored.
  - Direction: the new request is chosen by priority l > r > u > d among asserted buttons. A request equal to the reverse of the current dir is dropped and does not fall through to a lower priority. A request equal to the current dir has no effect. The direction register updates the cycle after the request. The step pulse uses dir as registered at the tick boundary.
  - Tick: tick increments each RUN cycle. When tick==TICK_DIV-1, tick wraps to 0 and a step is due. The first step pulse is asserted in the TICK_DIV-th RUN cycle.
  - Wall pre-check on the due cycle: if pos_x==0 and dir L, or pos_x==max and dir R, or pos_y==0 and dir U, or pos_y==max and dir D, no step pulse is emitted and the next state is OVER. Otherwise exactly one of l/r/u/d is 1 for that cycle.
  - edge_collision=1 in any RUN cycle -> OVER next cycle. A step due in that same cycle is suppressed.
  - Food check: chk is set on the cycle a step pulse is issued. On the following cycle the recorder output is valid; if pos==food, eat=1 for one cycle and score increments, saturating at 2**SCORE_W-1. chk then clears. There is no food check without a preceding step.
- OVER: game_over=1, playing=0, no step/load pulses, score held. start=1 -> LOAD, which clears the score.
- Reset mid-RUN: no step pulse is issued on the reset cycle; the next cycle shows the reset values.
- Simultaneous wall hit and food cell on the same due cycle: OVER wins, no eat.

Decomposition:
- Shared package snake_pkg: direction encoding (DIR_L/R/U/D, 2 bits), game state encoding (ST_IDLE/LOAD/RUN/OVER), GRID_MAX = 2**COORD_W-1, and the reverse-direction function.
- One sub-module, snake_dir_latch: button priority, reverse rejection and the dir register.
- Tick counter, FSM and scoring stay in the top module.

Test Plan:
- Power-up and start (defaults): reset 2 cycles, then start=1 for 1 cycle -> next cycle load=1, load_x=3, load_y=3. The following cycle playing=1. r pulses in RUN cycles 4, 8, 12, each exactly 1 cycle wide.
- Turn and reverse reject: dir=R, pulse btn_u 1 cycle -> subsequent steps on u only. Then pulse btn_d -> ignored, u steps continue. Then btn_l+btn_r together with dir=U -> l chosen.
- Wall pre-check: pos_x=7, dir=R at tick boundary -> r stays 0, next cycle game_over=1, playing=0. Repeat with pos_y=0, dir=U -> same result.
- edge_collision: assert for 1 cycle mid-RUN at tick=1 -> OVER next cycle, no further step pulses. start=1 -> LOAD, score reads 0.
- Food: food=(4,3), start at (3,3), dir=R -> r pulse, pos becomes (4,3), eat=1 for 1 cycle the cycle after the pulse, score=1. With SCORE_W=2 and 4 pickups, score saturates at 3.
- Reset in RUN on the cycle a step is due -> no pulse, all outputs at reset values next cycle, state IDLE, start needed to resume.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake step controller: step directions, game
// states, default grid extent and the reverse-direction helper.
package snake_pkg;

    localparam int COORD_W_DEF = 3;
    // Largest coordinate of the default 8x8 grid; the top derives its own from COORD_W.
    localparam int GRID_MAX = (2 ** COORD_W_DEF) - 1;

    typedef enum logic [1:0] {
        DIR_L = 2'd0,
        DIR_R = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    function automatic dir_e reverse_dir(input dir_e d);
        case (d)
            DIR_L:   reverse_dir = DIR_R;
            DIR_R:   reverse_dir = DIR_L;
            DIR_U:   reverse_dir = DIR_D;
            DIR_D:   reverse_dir = DIR_U;
            default: reverse_dir = DIR_R;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Direction register: picks one button request by fixed priority and
// refuses a request that would reverse the snake onto itself.
module snake_dir_latch
    import snake_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic btn_l,
    input  logic btn_r,
    input  logic btn_u,
    input  logic btn_d,
    output dir_e dir
);

    dir_e dir_r;
    dir_e req_s;
    logic req_valid_s;

    // Priority l > r > u > d; a rejected reverse never falls through to a lower button.
    always_comb begin
        req_s       = DIR_R;
        req_valid_s = 1'b1;
        if (btn_l) begin
            req_s = DIR_L;
        end else if (btn_r) begin
            req_s = DIR_R;
        end else if (btn_u) begin
            req_s = DIR_U;
        end else if (btn_d) begin
            req_s = DIR_D;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    // Direction state; cleared to RIGHT at reset and at every game load.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_r <= DIR_R;
        end else if (clear) begin
            dir_r <= DIR_R;
        end else if (enable && req_valid_s && (req_s != reverse_dir(dir_r))) begin
            dir_r <= req_s;
        end else begin
            dir_r <= dir_r;
        end
    end

    assign dir = dir_r;

endmodule

// File: rtl/snake_step_controller.sv
// Snake game sequencer: tick-paced step pulses, start-position load, wall and
// collision handling, food pickup scoring and the IDLE/LOAD/RUN/OVER flow.
module snake_step_controller
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int COORD_W  = 3,
    parameter int START_X  = 3,
    parameter int START_Y  = 3,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               btn_l,
    input  logic               btn_r,
    input  logic               btn_u,
    input  logic               btn_d,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               edge_collision,
    input  logic [COORD_W-1:0] food_x,
    input  logic [COORD_W-1:0] food_y,
    output logic               l,
    output logic               r,
    output logic               u,
    output logic               d,
    output logic               load,
    output logic [COORD_W-1:0] load_x,
    output logic [COORD_W-1:0] load_y,
    output logic               playing,
    output logic               game_over,
    output logic               eat,
    output logic [SCORE_W-1:0] score
);

    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]  TICK_PRE  = TICK_W'(TICK_DIV - 2);
    localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] COORD_MIN = {COORD_W{1'b0}};
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_e             state_r, state_s;
    logic [TICK_W-1:0]  tick_r, tick_s;
    logic               chk_r;
    dir_e               dir_s;
    logic               due_s, wall_s, food_hit_s;
    logic [3:0]         step_s;
    logic               load_s, eat_s, playing_s, game_over_s;
    logic [COORD_W-1:0] load_x_s, load_y_s;
    logic [SCORE_W-1:0] score_s;

    snake_dir_latch u_dir_latch (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_r == ST_LOAD),
        .enable (state_r == ST_RUN),
        .btn_l  (btn_l),
        .btn_r  (btn_r),
        .btn_u  (btn_u),
        .btn_d  (btn_d),
        .dir    (dir_s)
    );

    // Pulses are registered, so the step is decided one count early and is
    // visible while tick == TICK_DIV-1.
    always_comb begin
        due_s      = (tick_r == TICK_PRE);
        food_hit_s = chk_r && (pos_x == food_x) && (pos_y == food_y);
        case (dir_s)
            DIR_L:   wall_s = (pos_x == COORD_MIN);
            DIR_R:   wall_s = (pos_x == COORD_MAX);
            DIR_U:   wall_s = (pos_y == COORD_MIN);
            DIR_D:   wall_s = (pos_y == COORD_MAX);
            default: wall_s = 1'b0;
        endcase
    end

    // Game flow, step selection and scoring; every output is the next registered value.
    always_comb begin
        state_s     = state_r;
        tick_s      = {TICK_W{1'b0}};
        step_s      = 4'b0000;
        load_s      = 1'b0;
        load_x_s    = COORD_MIN;
        load_y_s    = COORD_MIN;
        eat_s       = 1'b0;
        score_s     = score;
        playing_s   = 1'b0;
        game_over_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_s  = ST_LOAD;
                    load_s   = 1'b1;
                    load_x_s = COORD_W'(START_X);
                    load_y_s = COORD_W'(START_Y);
                    score_s  = {SCORE_W{1'b0}};
                end else begin
                    game_over_s = (state_r == ST_OVER);
                end
            end
            ST_LOAD: begin
                state_s   = ST_RUN;
                playing_s = 1'b1;
                score_s   = {SCORE_W{1'b0}};
            end
            ST_RUN: begin
                tick_s = (tick_r == TICK_LAST) ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
                if (edge_collision || (due_s && wall_s)) begin
                    state_s     = ST_OVER;
                    game_over_s = 1'b1;
                end else begin
                    playing_s = 1'b1;
                    if (due_s) begin
                        case (dir_s)
                            DIR_L:   step_s = 4'b1000;
                            DIR_R:   step_s = 4'b0100;
                            DIR_U:   step_s = 4'b0010;
                            DIR_D:   step_s = 4'b0001;
                            default: step_s = 4'b0000;
                        endcase
                    end else begin
                        step_s = 4'b0000;
                    end
                    if (food_hit_s) begin
                        eat_s   = 1'b1;
                        score_s = (score == SCORE_MAX) ? score : score + SCORE_W'(1);
                    end else begin
                        eat_s = 1'b0;
                    end
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, tick, food-check flag and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tick_r       <= {TICK_W{1'b0}};
            chk_r        <= 1'b0;
            {l, r, u, d} <= 4'b0000;
            load         <= 1'b0;
            load_x       <= COORD_MIN;
            load_y       <= COORD_MIN;
            eat          <= 1'b0;
            score        <= {SCORE_W{1'b0}};
            playing      <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state_r      <= state_s;
            tick_r       <= tick_s;
            chk_r        <= l | r | u | d;
            {l, r, u, d} <= step_s;
            load         <= load_s;
            load_x       <= load_x_s;
            load_y       <= load_y_s;
            eat          <= eat_s;
            score        <= score_s;
            playing      <= playing_s;
            game_over    <= game_over_s;
        end
    end

endmodule

// File: tb/tb_snake_step_controller.sv
// Scoreboard bench: a game-level model predicts output events per cycle, a
// negedge monitor matches them against what the controller presents.
module tb_snake_step_controller;

    localparam int TD = 4;
    localparam int SW = 2;
    localparam int SX = 3;
    localparam int SY = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, edge_collision = 1'b0;
    logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic [2:0] pos_x = 3'd0, pos_y = 3'd0, food_x = 3'd0, food_y = 3'd0;
    logic l, r, u, d, load, playing, game_over, eat;
    logic [2:0] load_x, load_y;
    logic [SW-1:0] score;

    snake_step_controller #(
        .TICK_DIV(TD), .COORD_W(3), .START_X(SX), .START_Y(SY), .SCORE_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .pos_x(pos_x), .pos_y(pos_y), .edge_collision(edge_collision),
        .food_x(food_x), .food_y(food_y),
        .l(l), .r(r), .u(u), .d(d),
        .load(load), .load_x(load_x), .load_y(load_y),
        .playing(playing), .game_over(game_over), .eat(eat), .score(score)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] step;
        logic       load;
        logic [2:0] lx;
        logic [2:0] ly;
        logic       eat;
        int         score;
        logic       playing;
        logic       game_over;
    } ev_t;

    ev_t expq[$];
    int  checks = 0, errors = 0;
    bit  armed = 1'b0;

    // Game-level model: phase 0 idle, 1 load, 2 run, 3 over; dirs 0 L, 1 R, 2 U, 3 D.
    ev_t        cur;
    int         phase = 0, run_n = 0, mdir = 1, px = 0, py = 0;
    logic [3:0] prev_step = 4'b0000;
    bit         feed_head = 1'b0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    task automatic check_idle(string tag);
        check(tag, int'({l, r, u, d, load, eat, playing, game_over, load_x, load_y, score}), 0);
    endtask

    task automatic model_step(input bit st, input bit [3:0] b, input bit ec, input bit rs);
        ev_t nx;
        int  nphase, nn, ndir, req;
        bit  due, hit;
        nx.cyc = cyc + 1; nx.step = 4'b0000; nx.load = 1'b0; nx.lx = 3'd0; nx.ly = 3'd0;
        nx.eat = 1'b0; nx.score = cur.score; nx.playing = 1'b0; nx.game_over = 1'b0;
        nphase = phase; nn = run_n; ndir = mdir;
        if (rs) begin
            nphase = 0; nx.score = 0; ndir = 1; nn = 0;
        end else if (phase == 0 || phase == 3) begin
            if (st) begin
                nphase = 1; nx.load = 1'b1; nx.lx = 3'(SX); nx.ly = 3'(SY); nx.score = 0;
            end else begin
                nx.game_over = (phase == 3);
            end
        end else if (phase == 1) begin
            nphase = 2; nx.playing = 1'b1; nx.score = 0; nn = 1; ndir = 1;
        end else begin
            // Steps land on RUN cycles that are multiples of TD.
            due = ((run_n + 1) % TD) == 0;
            hit = due && ((mdir == 0 && px == 0) || (mdir == 1 && px == 7) ||
                          (mdir == 2 && py == 0) || (mdir == 3 && py == 7));
            nn = run_n + 1;
            if (ec || hit) begin
                nphase = 3; nx.game_over = 1'b1;
            end else begin
                nx.playing = 1'b1;
                if (due) nx.step = 4'b1000 >> mdir;
                nx.eat = (prev_step != 4'b0000) && (px == int'(food_x)) && (py == int'(food_y));
                if (nx.eat && cur.score < SMAX) nx.score = cur.score + 1;
            end
            req = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : b[0] ? 3 : -1;
            if (req >= 0 && req != (mdir ^ 1)) ndir = req;
        end
        if (nx.step != 4'b0000 || nx.load || nx.eat ||
            nx.playing != cur.playing || nx.game_over != cur.game_over)
            expq.push_back(nx);
        // Ideal position recorder reacting to this cycle's expected strobes.
        if (cur.load) begin
            px = SX; py = SY;
        end else begin
            case (cur.step)
                4'b1000: px = px - 1;
                4'b0100: px = px + 1;
                4'b0010: py = py - 1;
                4'b0001: py = py + 1;
                default: ;
            endcase
        end
        prev_step = cur.step; cur = nx; phase = nphase; run_n = nn; mdir = ndir;
    endtask

    task automatic cyc_do(input bit st, input bit [3:0] b, input bit ec, input bit rs);
        start = st; {btn_l, btn_r, btn_u, btn_d} = b; edge_collision = ec; reset = rs;
        if (feed_head) begin
            food_x = 3'(px); food_y = 3'(py);
        end
        model_step(st, b, ec, rs);
        @(posedge clk); #1;
        pos_x = 3'(px); pos_y = 3'(py);
    endtask

    // Ends any running game, starts a new one and returns at RUN cycle 1.
    task automatic new_game();
        cyc_do(1'b0, 4'b0000, 1'b1, 1'b0);
        cyc_do(1'b1, 4'b0000, 1'b0, 1'b0);
        cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    logic pp = 1'b0, pg = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        bit  evt;
        if (armed) begin
            evt = ({l, r, u, d} != 4'b0000) || load || eat || (playing != pp) || (game_over != pg);
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                e = expq.pop_front();
                check("stale_event", cyc, e.cyc);
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                if (!evt) begin
                    check("event_present", int'(evt), 1);
                end else begin
                    check("step_lrud", int'({l, r, u, d}), int'(e.step));
                    check("load", int'(load), int'(e.load));
                    check("load_x", int'(load_x), int'(e.lx));
                    check("load_y", int'(load_y), int'(e.ly));
                    check("eat", int'(eat), int'(e.eat));
                    check("score", int'(score), e.score);
                    check("playing", int'(playing), int'(e.playing));
                    check("game_over", int'(game_over), int'(e.game_over));
                end
            end else if (evt) begin
                check("spurious_event", int'(evt), 0);
            end
            pp <= playing;
            pg <= game_over;
        end
    end

    initial begin
        cur.cyc = 0; cur.step = 4'b0000; cur.load = 1'b0; cur.lx = 3'd0; cur.ly = 3'd0;
        cur.eat = 1'b0; cur.score = 0; cur.playing = 1'b0; cur.game_over = 1'b0;

        cyc_do(1'b0, 4'b0000, 1'b0, 1'b1);
        armed = 1'b1;
        cyc_do(1'b0, 4'b0000, 1'b0, 1'b1);
        check_idle("reset_state");

        // Straight run east from (3,3): food at (4,3), then the x=7 wall.
        food_x = 3'd4; food_y = 3'd3;
        cyc_do(1'b1, 4'b0000, 1'b0, 1'b0);
        repeat (24) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);

        // Turn up, reverse request dropped, then l+r together picks l.
        food_x = 3'd0; food_y = 3'd7;
        new_game();
        cyc_do(1'b0, 4'b0010, 1'b0, 1'b0);
        repeat (6) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc_do(1'b0, 4'b0001, 1'b0, 1'b0);
        repeat (3) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc_do(1'b0, 4'b1100, 1'b0, 1'b0);
        repeat (10) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);

        // Wall at y=0 heading up.
        new_game();
        cyc_do(1'b0, 4'b0010, 1'b0, 1'b0);
        repeat (20) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);

        // Collision flag at tick 1, then restart clears the score.
        new_game();
        cyc_do(1'b0, 4'b0000, 1'b1, 1'b0);
        repeat (6) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);

        // Food under the head after every step: four pickups saturate the score.
        feed_head = 1'b1;
        new_game();
        repeat (24) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);
        feed_head = 1'b0;

        // Reset on the cycle the first step is decided.
        new_game();
        repeat (2) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc_do(1'b0, 4'b0000, 1'b0, 1'b1);
        check_idle("reset_in_run");
        repeat (4) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);
        check_idle("stays_idle");

        for (int i = 0; i < 3000; i++) begin
            bit st, ec, rs;
            bit [3:0] b;
            st = ($urandom_range(0, 15) == 0);
            b  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            ec = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 63) == 0) feed_head = ~feed_head;
            if (!feed_head && $urandom_range(0, 31) == 0) begin
                food_x = 3'($urandom); food_y = 3'($urandom);
            end
            cyc_do(st, b, ec, rs);
        end

        repeat (4) cyc_do(1'b0, 4'b0000, 1'b0, 1'b0);
        check("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
